// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between core load/store and debug.
// Optional: DMEM_MISALIGN_CHK_EN adds core_misalign_o and misaligned-access trap.
// Ports: clk, rst_n; core_* (req/we/funct3/addr/wdata in; stall/done/rdata/
// addr_index out); dbg_* (req/we/addr/wdata/wstrb in; done/rdata out);
// mem_* (req/we/addr/wdata/wstrb out; ready/rdata in).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_funct3_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_stall_o,
  output logic              core_done_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic [1:0]        core_addr_index_o,
`ifdef DMEM_MISALIGN_CHK_EN
  output logic              core_misalign_o,
`endif
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic [3:0]        dbg_wstrb_i,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    CORE_BUSY,
    DBG_BUSY
  } state_t;

  state_t            state, state_nx;
  logic              last_dbg, last_dbg_nx;
  logic              grant_core, grant_dbg;
  logic              mis, mis_hit, finish;
  logic [3:0]        core_strb;
  logic [DATA_W-1:0] core_wdata;
  logic              unused_ok;

  assign unused_ok    = ^dbg_addr_i[1:0];
  assign core_stall_o = core_req_i & ~core_done_o;

`ifdef DMEM_MISALIGN_CHK_EN
  logic is_half, is_word;
  assign is_half = (core_funct3_i == 3'b001) |
                   (~core_we_i & (core_funct3_i == 3'b101));
  assign is_word = core_funct3_i == 3'b010;
  assign mis = (is_half & core_addr_i[0]) |
               (is_word & (core_addr_i[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // store lane placement; loads reuse the path but strobes are gated off
  always_comb begin
    core_strb  = 4'b0000;
    core_wdata = core_wdata_i;
    unique case (core_funct3_i)
      3'b000: begin
        core_strb  = 4'b0001 << core_addr_i[1:0];
        core_wdata = {4{core_wdata_i[7:0]}};
      end
      3'b001: begin
        core_strb  = core_addr_i[1] ? 4'b1100 : 4'b0011;
        core_wdata = {2{core_wdata_i[15:0]}};
      end
      3'b010:  core_strb = 4'b1111;
      default: core_strb = 4'b0000;
    endcase
  end

  always_comb begin
    state_nx    = state;
    last_dbg_nx = last_dbg;
    grant_core  = 1'b0;
    grant_dbg   = 1'b0;
    mis_hit     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      IDLE: begin
        // round-robin on a tie: favour whoever did not win last
        if (core_req_i && (!dbg_req_i || last_dbg)) begin
          last_dbg_nx = 1'b0;
          if (mis) begin
            mis_hit = 1'b1;
          end else begin
            grant_core = 1'b1;
            state_nx   = CORE_BUSY;
          end
        end else if (dbg_req_i) begin
          last_dbg_nx = 1'b1;
          grant_dbg   = 1'b1;
          state_nx    = DBG_BUSY;
        end
      end
      CORE_BUSY, DBG_BUSY: begin
        if (mem_ready_i) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_dbg <= 1'b1;
    end else begin
      state    <= state_nx;
      last_dbg <= last_dbg_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o         <= 1'b0;
      mem_we_o          <= 1'b0;
      mem_addr_o        <= '0;
      mem_wdata_o       <= '0;
      mem_wstrb_o       <= 4'b0000;
      core_done_o       <= 1'b0;
      dbg_done_o        <= 1'b0;
      core_rdata_o      <= '0;
      dbg_rdata_o       <= '0;
      core_addr_index_o <= 2'b00;
`ifdef DMEM_MISALIGN_CHK_EN
      core_misalign_o   <= 1'b0;
`endif
    end else begin
      core_done_o <= (finish && state == CORE_BUSY) || mis_hit;
      dbg_done_o  <= finish && state == DBG_BUSY;
`ifdef DMEM_MISALIGN_CHK_EN
      core_misalign_o <= mis_hit;
`endif
      if (grant_core || mis_hit) begin
        core_addr_index_o <= core_addr_i[1:0];
      end
      if (grant_core) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= core_we_i;
        mem_addr_o  <= {core_addr_i[ADDR_W-1:2], 2'b00};
        mem_wdata_o <= core_wdata;
        mem_wstrb_o <= core_we_i ? core_strb : 4'b0000;
      end else if (grant_dbg) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= dbg_we_i;
        mem_addr_o  <= {dbg_addr_i[ADDR_W-1:2], 2'b00};
        mem_wdata_o <= dbg_wdata_i;
        mem_wstrb_o <= dbg_we_i ? dbg_wstrb_i : 4'b0000;
      end else if (finish) begin
        mem_req_o <= 1'b0;
      end
      if (finish && !mem_we_o && state == CORE_BUSY) begin
        core_rdata_o <= mem_rdata_i;
      end
      if (finish && !mem_we_o && state == DBG_BUSY) begin
        dbg_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, directed sequences and random traffic
// checked against a cycle-level reference model of the arbiter.
module tb_dmem_arbiter;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        core_req_i = 0, core_we_i = 0;
  logic [2:0]  core_funct3_i = 0;
  logic [31:0] core_addr_i = 0, core_wdata_i = 0;
  logic        core_stall_o, core_done_o;
  logic [31:0] core_rdata_o;
  logic [1:0]  core_addr_index_o;
  logic        dbg_req_i = 0, dbg_we_i = 0;
  logic [31:0] dbg_addr_i = 0, dbg_wdata_i = 0;
  logic [3:0]  dbg_wstrb_i = 0;
  logic        dbg_done_o;
  logic [31:0] dbg_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i = 0;
  logic [31:0] mem_rdata_i = 0;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        core_misalign_o;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_funct3_i(core_funct3_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_stall_o(core_stall_o),
    .core_done_o(core_done_o), .core_rdata_o(core_rdata_o),
    .core_addr_index_o(core_addr_index_o),
`ifdef DMEM_MISALIGN_CHK_EN
    .core_misalign_o(core_misalign_o),
`endif
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_wstrb_i(dbg_wstrb_i), .dbg_done_o(dbg_done_o),
    .dbg_rdata_o(dbg_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model state: 0 idle, 1 core owns memory, 2 debug owns it
  int          m_owner;
  bit          m_last_dbg;
  logic [31:0] e_core_rdata, e_dbg_rdata, e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_we;
  logic [1:0]  e_idx;

  task automatic model_reset();
    m_owner = 0; m_last_dbg = 1;
    e_core_rdata = 0; e_dbg_rdata = 0; e_idx = 0;
    e_addr = 0; e_wdata = 0; e_wstrb = 0; e_we = 0;
  endtask

  task automatic exp_core(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] w,
                          output logic [3:0] s, output logic [31:0] d);
    case (f3)
      3'd0: begin
        s = 4'(1 << (a % 4));
        d = (w & 32'hFF) * 32'h0101_0101;
      end
      3'd1: begin
        s = ((a % 4) >= 2) ? 4'hC : 4'h3;
        d = (w & 32'hFFFF) * 32'h0001_0001;
      end
      3'd2: begin s = 4'hF; d = w; end
      default: begin s = 4'h0; d = w; end
    endcase
    if (!we) s = 4'h0;
  endtask

`ifdef DMEM_MISALIGN_CHK_EN
  function automatic bit is_mis(logic we, logic [2:0] f3, logic [31:0] a);
    bit half = (f3 == 3'd1) || (!we && f3 == 3'd5);
    return (half && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
  endfunction
`endif

  // inputs are still those sampled at the last posedge when this runs
  task automatic model_step();
    logic ed_c, ed_d, em;
    ed_c = 0; ed_d = 0; em = 0;
    if (m_owner == 0) begin
      if (core_req_i && (!dbg_req_i || m_last_dbg)) begin
        m_last_dbg = 0;
        e_idx = core_addr_i[1:0];
`ifdef DMEM_MISALIGN_CHK_EN
        if (is_mis(core_we_i, core_funct3_i, core_addr_i)) begin
          ed_c = 1; em = 1;
        end else
`endif
        begin
          m_owner = 1;
          e_we = core_we_i;
          e_addr = core_addr_i & ~32'd3;
          exp_core(core_we_i, core_funct3_i, core_addr_i,
                   core_wdata_i, e_wstrb, e_wdata);
        end
      end else if (dbg_req_i) begin
        m_last_dbg = 1;
        m_owner = 2;
        e_we = dbg_we_i;
        e_addr = dbg_addr_i & ~32'd3;
        e_wdata = dbg_wdata_i;
        e_wstrb = dbg_we_i ? dbg_wstrb_i : 4'h0;
      end
    end else if (mem_ready_i) begin
      if (!e_we && m_owner == 1) e_core_rdata = mem_rdata_i;
      if (!e_we && m_owner == 2) e_dbg_rdata = mem_rdata_i;
      ed_c = (m_owner == 1);
      ed_d = (m_owner == 2);
      m_owner = 0;
    end
    chk("mem_req", mem_req_o, m_owner != 0);
    chk("core_done", core_done_o, ed_c);
    chk("dbg_done", dbg_done_o, ed_d);
    chk("core_stall", core_stall_o, core_req_i & ~ed_c);
    chk("core_rdata", core_rdata_o, e_core_rdata);
    chk("dbg_rdata", dbg_rdata_o, e_dbg_rdata);
    chk("addr_index", core_addr_index_o, e_idx);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign", core_misalign_o, em);
`endif
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, e_we);
      chk("mem_wstrb", mem_wstrb_o, e_wstrb);
      if (e_we) chk("mem_wdata", mem_wdata_o, e_wdata);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    core_req_i = 0; dbg_req_i = 0; mem_ready_i = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
    chk("rst mem_req", mem_req_o, 0);
    chk("rst mem_we", mem_we_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_wdata", mem_wdata_o, 0);
    chk("rst mem_wstrb", mem_wstrb_o, 0);
    chk("rst core_done", core_done_o, 0);
    chk("rst dbg_done", dbg_done_o, 0);
    chk("rst core_rdata", core_rdata_o, 0);
    chk("rst dbg_rdata", dbg_rdata_o, 0);
    chk("rst addr_index", core_addr_index_o, 0);
  endtask

  task automatic set_core(logic we, logic [2:0] f3,
                          logic [31:0] a, logic [31:0] w);
    core_we_i = we; core_funct3_i = f3;
    core_addr_i = a; core_wdata_i = w; core_req_i = 1;
  endtask

  // bounded wait for a done pulse; returns ticks taken, -1 on timeout
  task automatic wait_done(input bit is_dbg, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (is_dbg ? dbg_done_o : core_done_o) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("done timeout", 1, 0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [31:0] xdata;
  } vec_t;

  vec_t vq[$];
  int   n;

  initial begin
    vq.push_back('{1, 3'd0, 32'h102, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5});
    vq.push_back('{1, 3'd0, 32'h103, 32'h1234_56C3, 4'b1000, 32'hC3C3_C3C3});
    vq.push_back('{1, 3'd0, 32'h100, 32'hFFFF_FF77, 4'b0001, 32'h7777_7777});
    vq.push_back('{1, 3'd0, 32'h101, 32'h0000_0019, 4'b0010, 32'h1919_1919});
    vq.push_back('{1, 3'd1, 32'h206, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF});
    vq.push_back('{1, 3'd1, 32'h204, 32'hCAFE_1234, 4'b0011, 32'h1234_1234});
    vq.push_back('{1, 3'd2, 32'h208, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF});
    vq.push_back('{1, 3'd3, 32'h20C, 32'h0000_0055, 4'b0000, 32'h0000_0055});
    vq.push_back('{0, 3'd2, 32'h210, 32'h0000_0000, 4'b0000, 32'h0000_0000});
`ifndef DMEM_MISALIGN_CHK_EN
    vq.push_back('{1, 3'd1, 32'h207, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD});
`endif

    do_reset();

    // table: core accesses with memory always ready
    mem_ready_i = 1;
    foreach (vq[i]) begin
      set_core(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata);
      mem_rdata_i = 32'h5A00_0000 + i;
      #1 chk("vec stall", core_stall_o, 1);
      tick();
      chk("vec addr", mem_addr_o, vq[i].addr & ~32'd3);
      chk("vec wstrb", mem_wstrb_o, vq[i].strb);
      if (vq[i].we) chk("vec wdata", mem_wdata_o, vq[i].xdata);
      tick();
      chk("vec done@2", core_done_o, 1);
      core_req_i = 0;
      tick();
    end

    // load with memory ready delayed
    mem_ready_i = 0;
    set_core(0, 3'd2, 32'h200, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req_o) n++;
    end
    mem_ready_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    chk("lw req cycles", n, 4);
    chk("lw done", core_done_o, 1);
    chk("lw rdata", core_rdata_o, 32'hDEAD_BEEF);
    chk("lw index", core_addr_index_o, 2'b00);
    core_req_i = 0;
    tick();

    // debug write leaves the core read word alone
    dbg_we_i = 1; dbg_addr_i = 32'h3FC;
    dbg_wstrb_i = 4'b1001; dbg_wdata_i = 32'h1122_3344;
    dbg_req_i = 1;
    tick();
    chk("dbg wstrb", mem_wstrb_o, 4'b1001);
    chk("dbg wdata", mem_wdata_o, 32'h1122_3344);
    chk("dbg addr", mem_addr_o, 32'h3FC);
    wait_done(1, n);
    dbg_req_i = 0;
    tick();
    chk("dbg single pulse", dbg_done_o, 0);
    chk("dbg keeps core rdata", core_rdata_o, 32'hDEAD_BEEF);

    // reset mid-transaction
    mem_ready_i = 0;
    set_core(1, 3'd2, 32'h40, 32'h0BAD_F00D);
    tick();
    tick();
    #2 rst_n = 0;
    #1 chk("async drop req", mem_req_o, 0);
    chk("no done on rst", core_done_o, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    mem_ready_i = 1;
    tick();
    chk("restart req", mem_req_o, 1);
    tick();
    chk("restart done", core_done_o, 1);
    core_req_i = 0;

    // tie arbitration after reset
    do_reset();
    mem_ready_i = 1;
    set_core(0, 3'd2, 32'h10, 0);
    dbg_we_i = 0; dbg_addr_i = 32'h20; dbg_req_i = 1;
    begin
      logic [31:0] order[$];
      logic        prev;
      prev = 0;
      for (int i = 0; i < 40 && order.size() < 3; i++) begin
        tick();
        if (mem_req_o && !prev) order.push_back(mem_addr_o);
        prev = mem_req_o;
        if (core_done_o) core_req_i = 0;
        else if (!core_req_i) core_req_i = 1;
        if (dbg_done_o) dbg_req_i = 0;
        else if (!dbg_req_i) dbg_req_i = 1;
      end
      chk("rr grants", order.size(), 3);
      while (order.size() < 3) order.push_back('x);
      chk("rr first core", order[0], 32'h10);
      chk("rr second dbg", order[1], 32'h20);
      chk("rr third core", order[2], 32'h10);
    end

`ifdef DMEM_MISALIGN_CHK_EN
    do_reset();
    set_core(0, 3'd2, 32'h102, 0);
    tick();
    chk("mis done", core_done_o, 1);
    chk("mis flag", core_misalign_o, 1);
    chk("mis no req", mem_req_o, 0);
    core_req_i = 0;
    tick();
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (core_done_o) core_req_i = 0;
      else if (!core_req_i && $urandom_range(0, 2) == 0)
        set_core(1'($urandom), 3'($urandom), $urandom, $urandom);
      if (dbg_done_o) dbg_req_i = 0;
      else if (!dbg_req_i && $urandom_range(0, 2) == 0) begin
        dbg_we_i = 1'($urandom); dbg_addr_i = $urandom;
        dbg_wdata_i = $urandom; dbg_wstrb_i = 4'($urandom);
        dbg_req_i = 1;
      end
      mem_ready_i = 1'($urandom);
      mem_rdata_i = $urandom;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core load/store path and a debug/DMA requester.
- Sequences each access through a request/ready handshake with memory.
- Converts core store funct3 plus address into byte strobes and lane-replicated write data.
- Returns the raw read word and the latched byte index to the writeback stage. Core is stalled until its access completes.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, since strobe logic is 4 lanes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core access request; held until core_done_o
- core_we_i  in  1  1 = store, 0 = load
- core_funct3_i  in  3  RV32I load/store funct3
- core_addr_i  in  ADDR_W  byte address
- core_wdata_i  in  DATA_W  store data, right-aligned
- core_stall_o  out  1  core_req_i & ~core_done_o
- core_done_o  out  1  one-cycle completion pulse
- core_rdata_o  out  DATA_W  raw memory word, registered
- core_addr_index_o  out  2  latched core_addr_i[1:0] for load lane select
- dbg_req_i  in  1  debug request; held until dbg_done_o
- dbg_we_i  in  1  debug write
- dbg_addr_i  in  ADDR_W  word address; bits [1:0] ignored
- dbg_wdata_i  in  DATA_W  debug write data
- dbg_wstrb_i  in  4  debug byte strobes
- dbg_done_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  DATA_W  registered read word
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  word-aligned; bits [1:0] = 0
- mem_wdata_o  out  DATA_W  lane-placed write data
- mem_wstrb_o  out  4  byte enables; 0 on reads
- mem_ready_i  in  1  memory accepts/completes in this cycle; read data valid in the same cycle
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, last_grant = DBG.
  - All registered outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, core_done_o, dbg_done_o, core_rdata_o, dbg_rdata_o, core_addr_index_o.
  - A reset during BUSY drops mem_req_o immediately. The transaction is abandoned with no done pulse.
- FSM states: IDLE, CORE_BUSY, DBG_BUSY.
- IDLE, on a clock edge:
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to last_grant (round-robin). After reset the core wins the first tie.
  - On grant, register the mem_* outputs, set mem_req_o = 1, update last_grant, go to *_BUSY.
  - For a core grant, also latch core_addr_index_o = core_addr_i[1:0].
- BUSY: mem_* outputs held stable. On a cycle with mem_ready_i = 1:
  - mem_rdata_i is captured into the owner's rdata register.
  - The owner's done is pulsed on the next cycle; mem_req_o deasserts on that same edge.
  - state returns to IDLE.
- Minimum latency, request to done:
  - Request sampled in IDLE at edge 0; mem_req_o is high from edge 0.
  - mem_ready_i is high in the following cycle; done is high after edge 1.
  - IDLE is re-entered with done. A new grant is possible on the next edge, so there is one bubble cycle between transactions.
- Core store mapping, with off = addr[1:0]:
  - SB: wstrb = 4'b0001 << off; wdata = byte replicated x4.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated x2.
  - SW: wstrb = 4'b1111; wdata unchanged.
  - Other funct3: wstrb = 4'b0000, and the access still completes the handshake.
- Core load: wstrb = 0, we = 0. Sign/zero extension is done downstream using core_addr_index_o.
- core_rdata_o / dbg_rdata_o:
  - Update only on a read completion of their own owner.
  - Hold otherwise, including after writes.
- Requester deasserting req mid-BUSY is illegal; the access completes regardless.
- A done pulse and a new req in the same cycle is treated as a new request.
- mem_ready_i while IDLE is ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined:
  - A core access is misaligned when LH/LHU/SH has addr[0] = 1, or LW/SW has addr[1:0] != 0.
  - A misaligned core grant is not issued to memory: mem_req_o stays 0.
  - The FSM goes IDLE -> IDLE and pulses core_done_o and extra output core_misalign_o (1 bit, reset 0) on the next cycle.
  - core_rdata_o is unchanged; last_grant is updated as for a normal grant.
- Not defined:
  - core_misalign_o is absent.
  - Low address bits beyond the strobe rules above are ignored, so a misaligned halfword uses addr[1] only.

Test Plan:
1. Core SB to addr 0x0000_0102, wdata 0x0000_00A5 -> mem_addr_o = 0x100, mem_wstrb_o = 4'b0100, mem_wdata_o = 0xA5A5A5A5; with mem_ready_i held 1, core_done_o pulses 2 cycles after req; core_stall_o high until done.
2. Core LW at 0x200, mem_ready_i delayed 3 cycles, mem_rdata_i = 0xDEADBEEF -> mem_req_o held high 4 cycles with stable addr; core_rdata_o = 0xDEADBEEF; core_addr_index_o = 2'b00.
3. core_req_i and dbg_req_i asserted together, both held, three times -> grant order after reset is core, dbg, core; one bubble cycle between each; no overlapping mem_req_o.
4. Debug write at 0x3FC, wstrb 4'b1001, data 0x11223344 -> mem_wstrb_o = 4'b1001, mem_wdata_o = 0x11223344; dbg_done_o one pulse; core_rdata_o unchanged.
5. rst_n low for 1 cycle while in CORE_BUSY -> mem_req_o falls asynchronously; no core_done_o pulse; after release, a held core_req_i restarts from IDLE.
6. With DMEM_MISALIGN_CHK_EN: core LW at 0x102 -> mem_req_o never high; core_done_o and core_misalign_o pulse together 1 cycle after req.
